// File: rtl/wf_ram_reader.sv
// wf_ram_reader: plays back a waveform table from the consumer port of the
// waveform DPBRAM at a programmable sample period. Each sample is emitted as a
// one-cycle strobe, and a running read count is kept alongside.
// Optional feature: define WF_READER_LOOP_EN to enable wrap-around playback
// selected by i_loop. When it is undefined, every run is single-shot.
module wf_ram_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_loop,
  input  logic [ADDR_WIDTH:0]   i_wf_len,
  input  logic [DIV_WIDTH-1:0]  i_wf_div,
  output logic [ADDR_WIDTH-1:0] o_wf_ram_addr,
  output logic                  o_wf_ram_ce,
  output logic                  o_wf_ram_we,
  input  logic [DATA_WIDTH-1:0] i_wf_ram_dout,
  output logic [DATA_WIDTH-1:0] o_wf_data,
  output logic                  o_wf_valid,
  output logic                  o_wf_busy,
  output logic                  o_wf_done,
  output logic [31:0]           o_wf_read_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CAPTURE, S_WAIT} state_t;

  localparam logic [ADDR_WIDTH:0]  LEN_ONE = 1;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH:0]     len_q;
  logic [DIV_WIDTH-1:0]    div_q;
  logic [DIV_WIDTH-1:0]    wait_cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [31:0]             read_cnt;
  logic                    loop_on;
  logic                    start_ok;
  logic                    is_last;
  logic                    capture_go;

  assign start_ok   = (state == S_IDLE) && i_start && !i_stop && (i_wf_len != '0);
  assign is_last    = ({1'b0, idx} == (len_q - LEN_ONE));
  // A stop in the capture cycle swallows that sample entirely.
  assign capture_go = (state == S_CAPTURE) && !i_stop;

`ifdef WF_READER_LOOP_EN
  logic loop_q;

  // Loop mode is latched at start so mid-run changes of i_loop are ignored.
  always_ff @(posedge i_clk) begin
    if (i_rst)         loop_q <= 1'b0;
    else if (start_ok) loop_q <= i_loop;
  end

  assign loop_on = loop_q;
`else
  logic unused_loop;
  assign unused_loop = i_loop;
  assign loop_on     = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Stop from any busy state overrides everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_ok) state_nxt = S_READ;
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (is_last && !loop_on) state_nxt = S_IDLE;
        else if (div_q != '0)    state_nxt = S_WAIT;
        else                     state_nxt = S_READ;
      end
      S_WAIT:    if (wait_cnt == '0) state_nxt = S_READ;
      default:   state_nxt = S_IDLE;
    endcase
    if ((state != S_IDLE) && i_stop) state_nxt = S_IDLE;
  end

  // Datapath: latched config, read index, wait counter, held sample, count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q    <= '0;
      div_q    <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      read_cnt <= '0;
    end else begin
      if (start_ok) begin
        len_q    <= i_wf_len;
        div_q    <= i_wf_div;
        idx      <= '0;
        read_cnt <= '0;
      end
      if (capture_go) begin
        data_q <= i_wf_ram_dout;
        if (read_cnt != '1) read_cnt <= read_cnt + 32'd1;
        if (!is_last)       idx <= idx + 1'b1;
        else if (loop_on)   idx <= '0;
        // Loaded with div-1 so WAIT lasts exactly div cycles; unused when div=0.
        wait_cnt <= div_q - DIV_ONE;
      end
      if ((state == S_WAIT) && (wait_cnt != '0)) wait_cnt <= wait_cnt - DIV_ONE;
    end
  end

  // Outputs. Data shows the RAM word in the strobe cycle and holds it after.
  always_comb begin
    o_wf_ram_addr = idx;
    o_wf_ram_ce   = (state == S_READ);
    o_wf_ram_we   = 1'b0;
    o_wf_valid    = capture_go;
    o_wf_done     = capture_go && is_last && !loop_on;
    o_wf_data     = capture_go ? i_wf_ram_dout : data_q;
    o_wf_busy     = (state != S_IDLE);
    o_wf_read_cnt = read_cnt;
  end

endmodule
